piso_tx: RTL



---
 rtl/piso_tx.sv | 112 +++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter with a one-word holding register so that
// back-to-back words stream with no idle bit between them.
module piso_tx #(
  parameter int unsigned SIZE       = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [SIZE-1:0] data_in,
  input  logic            data_valid,
  output logic            data_ready,
  output logic            out,
  output logic            frame,
  output logic            done,
  output logic            busy
);

  localparam int unsigned      CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SIZE - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [SIZE-1:0]   hold_reg, hold_nxt;
  logic              hold_full, hold_full_nxt;
  logic [SIZE-1:0]   shift_reg, shift_nxt;
  logic [CNT_W-1:0]  bit_count, count_nxt;
  logic              out_nxt, frame_nxt, done_nxt;
  logic              accept, last_bit, load;

  assign data_ready = ~hold_full & ~reset;
  assign accept     = data_valid & data_ready;
  assign busy       = (state == SHIFT) | hold_full;
  assign last_bit   = (state == SHIFT) && (bit_count == LAST);
  // A held word is loaded from IDLE or straight after the last bit, so no gap appears.
  assign load       = enable & hold_full & ((state == IDLE) | last_bit);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      case (state)
        IDLE:    if (hold_full) state_nxt = SHIFT;
        SHIFT:   if (bit_count == LAST && !hold_full) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    hold_nxt      = hold_reg;
    hold_full_nxt = hold_full;
    shift_nxt     = shift_reg;
    count_nxt     = bit_count;
    out_nxt       = out;
    frame_nxt     = frame;
    done_nxt      = 1'b0;

    if (accept) begin
      hold_nxt      = data_in;
      hold_full_nxt = 1'b1;
    end

    if (enable && state == SHIFT) begin
      if (bit_count == LAST) begin
        done_nxt  = 1'b1;
        out_nxt   = IDLE_LEVEL;
        frame_nxt = 1'b0;
      end else begin
        out_nxt   = MSB_FIRST ? shift_reg[SIZE-1] : shift_reg[0];
        shift_nxt = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
        count_nxt = bit_count + CNT_W'(1);
      end
    end

    // shift_reg keeps only the bits still to be sent; the first goes straight to out.
    if (load) begin
      hold_full_nxt = 1'b0;
      out_nxt       = MSB_FIRST ? hold_reg[SIZE-1] : hold_reg[0];
      shift_nxt     = MSB_FIRST ? (hold_reg << 1) : (hold_reg >> 1);
      count_nxt     = '0;
      frame_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      bit_count <= '0;
      out       <= IDLE_LEVEL;
      frame     <= 1'b0;
      done      <= 1'b0;
    end else begin
      hold_reg  <= hold_nxt;
      hold_full <= hold_full_nxt;
      shift_reg <= shift_nxt;
      bit_count <= count_nxt;
      out       <= out_nxt;
      frame     <= frame_nxt;
      done      <= done_nxt;
    end
  end

endmodule
